// File: rtl/if_stage_ibuf_pkg.sv
// Shared types and bus layout for the fetch-stage instruction buffer.
package if_stage_ibuf_pkg;

   localparam int unsigned PS_TO_FS_BUS_WD = 41;
   localparam int unsigned FS_TO_DS_BUS_WD = 74;

   // pre-IF bus: {s0_ex, s0_refill_ex, ecode[5:0], ex, pc[31:0]}
   localparam int unsigned PS_EX_BIT   = 32;
   localparam int unsigned PS_INFO_LSB = 32;

   localparam logic [9:0] CACOP_OPC = 10'b0000011000;

   typedef enum logic {
      ST_WAIT,
      ST_READY
   } entry_state_e;

   typedef struct packed {
      logic                       valid;
      entry_state_e               state;
      logic [PS_TO_FS_BUS_WD-1:0] ps_bus;
      logic [31:0]                inst;
      logic                       icacop;
   } ibuf_entry_t;

   function automatic logic is_cacop(input logic [31:0] inst);
      return (inst[31:22] == CACOP_OPC) && (inst[2:0] == 3'b000);
   endfunction

   // ID bus: {icacop, s0_ex, s0_refill_ex, ecode, ex, inst, pc}
   function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_ds_bus(input ibuf_entry_t e);
      return {e.icacop, e.ps_bus[PS_TO_FS_BUS_WD-1:PS_INFO_LSB], e.inst, e.ps_bus[31:0]};
   endfunction

endpackage

// File: rtl/if_stage_ibuf_if.sv
// Handshake and data signals between pre-IF, inst sram, IF and ID.
interface if_stage_ibuf_if;
   import if_stage_ibuf_pkg::*;

   logic                       ps_to_fs_valid;
   logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus;
   logic                       fs_allowin;
   logic                       data_ok;
   logic [31:0]                inst_sram_rdata;
   logic                       flush;
   logic                       ds_allowin;
   logic                       fs_to_ds_valid;
   logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
   logic                       fs_is_icacop;
   logic                       fs_busy;

   modport slave (
      input  ps_to_fs_valid, ps_to_fs_bus, data_ok, inst_sram_rdata, flush, ds_allowin,
      output fs_allowin, fs_to_ds_valid, fs_to_ds_bus, fs_is_icacop, fs_busy
   );

   modport master (
      output ps_to_fs_valid, ps_to_fs_bus, data_ok, inst_sram_rdata, flush, ds_allowin,
      input  fs_allowin, fs_to_ds_valid, fs_to_ds_bus, fs_is_icacop, fs_busy
   );

endinterface

// File: rtl/if_stage_ibuf_ring.sv
// Ring of fetch entries: storage, head/tail/count and oldest-WAIT lookup.
module fs_ibuf_ring
   import if_stage_ibuf_pkg::*;
#(
   parameter int unsigned IBUF_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             push,
   input  logic                             push_ex,
   input  logic [PS_TO_FS_BUS_WD-1:0]       push_bus,
   input  logic                             fill,
   input  logic [31:0]                      fill_inst,
   input  logic                             fill_icacop,
   input  logic                             pop,
   input  logic                             flush,
   output ibuf_entry_t                      head_entry,
   output logic [$clog2(IBUF_DEPTH):0]      count,
   output logic [$clog2(IBUF_DEPTH):0]      wait_cnt,
   output logic                             has_wait,
   output logic                             any_icacop,
   output logic                             any_valid
);
   localparam int unsigned PW = $clog2(IBUF_DEPTH);

   ibuf_entry_t   ent [IBUF_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] fill_idx;
   logic [PW-1:0] scan_idx;

   assign head_entry = ent[head];

   // Scan from head so the first WAIT hit is the oldest outstanding request.
   always_comb begin
      has_wait   = 1'b0;
      fill_idx   = head;
      scan_idx   = head;
      wait_cnt   = '0;
      any_icacop = 1'b0;
      any_valid  = 1'b0;
      for (int unsigned i = 0; i < IBUF_DEPTH; i++) begin
         scan_idx = head + PW'(i);
         if (ent[scan_idx].valid) begin
            any_valid = 1'b1;
            if (ent[scan_idx].icacop) any_icacop = 1'b1;
            if (ent[scan_idx].state == ST_WAIT) begin
               wait_cnt = wait_cnt + (PW+1)'(1);
               if (!has_wait) begin
                  has_wait = 1'b1;
                  fill_idx = scan_idx;
               end
            end
         end
      end
   end

   // Entry storage; pop, fill and push always target distinct slots.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < IBUF_DEPTH; i++) ent[i] <= '0;
      end else if (flush) begin
         for (int unsigned i = 0; i < IBUF_DEPTH; i++) ent[i].valid <= 1'b0;
      end else begin
         if (pop) ent[head].valid <= 1'b0;
         if (fill) begin
            ent[fill_idx].state  <= ST_READY;
            ent[fill_idx].inst   <= fill_inst;
            ent[fill_idx].icacop <= fill_icacop;
         end
         if (push) begin
            ent[tail] <= '{valid: 1'b1, state: (push_ex ? ST_READY : ST_WAIT),
                           ps_bus: push_bus, inst: '0, icacop: 1'b0};
         end
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(pop);
         tail  <= tail + PW'(push);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

endmodule

// File: rtl/if_stage_ibuf.sv
// Fetch stage: in-order instruction buffer between pre-IF/inst sram and ID.
module if_stage_ibuf
   import if_stage_ibuf_pkg::*;
#(
   parameter int unsigned IBUF_DEPTH = 4
) (
   input logic            clk,
   input logic            resetn,
   if_stage_ibuf_if.slave fs
);
   localparam int unsigned PW = $clog2(IBUF_DEPTH);
   localparam int unsigned DW = $clog2(IBUF_DEPTH + 1);

   ibuf_entry_t   head_entry;
   logic [PW:0]   count;
   logic [PW:0]   wait_cnt;
   logic          has_wait;
   logic          any_icacop;
   logic          any_valid;
   logic          push;
   logic          pop;
   logic          fill;
   logic          drop;
   logic          consume;
   logic [DW-1:0] discard_cnt;
   logic [DW:0]   discard_sum;

   assign fs.fs_allowin     = count < (PW+1)'(IBUF_DEPTH);
   assign push              = fs.ps_to_fs_valid && fs.fs_allowin && !fs.flush;
   assign drop              = fs.data_ok && (discard_cnt != '0);
   assign fill              = fs.data_ok && (discard_cnt == '0) && has_wait;
   assign consume           = drop || fill;
   assign fs.fs_to_ds_valid = head_entry.valid && (head_entry.state == ST_READY) && !fs.flush;
   assign pop               = fs.fs_to_ds_valid && fs.ds_allowin;
   assign fs.fs_to_ds_bus   = head_entry.valid ? pack_ds_bus(head_entry) : '0;
   assign fs.fs_is_icacop   = any_icacop;
   assign fs.fs_busy        = any_valid || (discard_cnt != '0);

   fs_ibuf_ring #(
      .IBUF_DEPTH (IBUF_DEPTH)
   ) u_ring (
      .clk         (clk),
      .resetn      (resetn),
      .push        (push),
      .push_ex     (fs.ps_to_fs_bus[PS_EX_BIT]),
      .push_bus    (fs.ps_to_fs_bus),
      .fill        (fill),
      .fill_inst   (fs.inst_sram_rdata),
      .fill_icacop (is_cacop(fs.inst_sram_rdata)),
      .pop         (pop),
      .flush       (fs.flush),
      .head_entry  (head_entry),
      .count       (count),
      .wait_cnt    (wait_cnt),
      .has_wait    (has_wait),
      .any_icacop  (any_icacop),
      .any_valid   (any_valid)
   );

   // On flush every WAIT entry becomes a stale response; a response landing
   // this same cycle (stale or live) is already accounted for.
   always_comb begin
      discard_sum = (DW+1)'(discard_cnt) + (DW+1)'(wait_cnt) - (DW+1)'(consume);
   end

   // Stale-response counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         discard_cnt <= '0;
      end else if (fs.flush) begin
         discard_cnt <= discard_sum[DW-1:0];
      end else if (drop) begin
         discard_cnt <= discard_cnt - DW'(1);
      end
   end

   // A response is only legal while some request, stale or live, is outstanding.
   assert property (@(posedge clk) disable iff (!resetn)
                    fs.data_ok |-> (discard_cnt != '0 || has_wait))
      else $error("if_stage_ibuf: data_ok with no outstanding request");

endmodule

// File: tb/tb_if_stage_ibuf.sv
// Randomized and directed bench for if_stage_ibuf with a queue-based model.
module tb_if_stage_ibuf;
   import if_stage_ibuf_pkg::*;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;

   if_stage_ibuf_if bus_if ();

   if_stage_ibuf #(.IBUF_DEPTH(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .fs     (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [40:0] ps;
      bit          ready;
      logic [31:0] inst;
      bit          icacop;
   } m_ent_t;

   m_ent_t mq[$];
   int     m_discard = 0;

   function automatic int m_waits();
      int n = 0;
      foreach (mq[i]) if (!mq[i].ready) n++;
      return n;
   endfunction

   task automatic check(input string nm, input logic [73:0] got, input logic [73:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Model: advance on each rising edge from the inputs presented that cycle.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mq.delete();
         m_discard = 0;
      end else begin
         int     n;
         int     w;
         bit     popd;
         m_ent_t e;
         n = mq.size();
         if (bus_if.flush) begin
            w = m_waits();
            m_discard = m_discard + w - ((bus_if.data_ok && (m_discard > 0 || w > 0)) ? 1 : 0);
            mq.delete();
         end else begin
            popd = (n > 0) && mq[0].ready && bus_if.ds_allowin;
            if (bus_if.data_ok) begin
               if (m_discard > 0) m_discard--;
               else begin
                  for (int i = 0; i < mq.size(); i++) begin
                     if (!mq[i].ready) begin
                        e = mq[i];
                        e.ready  = 1;
                        e.inst   = bus_if.inst_sram_rdata;
                        e.icacop = (bus_if.inst_sram_rdata[31:22] == 10'b0000011000) &&
                                   (bus_if.inst_sram_rdata[2:0] == 3'b000);
                        mq[i] = e;
                        break;
                     end
                  end
               end
            end
            if (popd) void'(mq.pop_front());
            if (bus_if.ps_to_fs_valid && n < 4) begin
               e.ps     = bus_if.ps_to_fs_bus;
               e.ready  = bus_if.ps_to_fs_bus[32];
               e.inst   = '0;
               e.icacop = 0;
               mq.push_back(e);
            end
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      logic [73:0] eb;
      bit          ev;
      bit          ei;
      ev = (mq.size() > 0) && mq[0].ready && !bus_if.flush;
      eb = '0;
      if (mq.size() > 0) eb = {mq[0].icacop, mq[0].ps[40:32], mq[0].inst, mq[0].ps[31:0]};
      ei = 0;
      foreach (mq[i]) if (mq[i].icacop) ei = 1;
      check("fs_allowin", bus_if.fs_allowin, mq.size() < 4);
      check("fs_to_ds_valid", bus_if.fs_to_ds_valid, ev);
      check("fs_to_ds_bus", bus_if.fs_to_ds_bus, eb);
      check("fs_is_icacop", bus_if.fs_is_icacop, ei);
      check("fs_busy", bus_if.fs_busy, (mq.size() != 0) || (m_discard != 0));
   end

   function automatic logic [40:0] ps(input logic [31:0] pc, input bit ex, input logic [5:0] ecode);
      return {2'b00, ecode, ex, pc};
   endfunction

   task automatic drive(input bit pv, input logic [40:0] pb, input bit dok,
                        input logic [31:0] rd, input bit fl, input bit dsa);
      bus_if.ps_to_fs_valid  = pv;
      bus_if.ps_to_fs_bus    = pb;
      bus_if.data_ok         = dok;
      bus_if.inst_sram_rdata = rd;
      bus_if.flush           = fl;
      bus_if.ds_allowin      = dsa;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit dsa);
      drive(0, '0, 0, '0, 0, dsa);
   endtask

   // Drain everything outstanding, feeding responses, then require an idle stage.
   task automatic settle();
      int k = 0;
      while ((mq.size() != 0 || m_discard != 0) && k < 60) begin
         drive(0, '0, (m_discard + m_waits()) > 0, 32'h00200000 + 32'(k), 0, 1);
         tick();
         k++;
      end
      idle(1);
      @(negedge clk);
      check("settle_busy", bus_if.fs_busy, 0);
      tick();
   endtask

   initial begin
      idle(1);
      repeat (2) tick();
      resetn = 1'b1;
      tick();

      // Streaming: each fill reaches ID one cycle after its data_ok.
      for (int k = 0; k < 6; k++) begin
         drive(k < 4, ps(32'h1c000000 + 32'(4 * k), 0, 6'h0), (k >= 1 && k <= 4),
               32'h02800000 + 32'(k - 1), 0, 1);
         @(negedge clk);
         if (k >= 2) begin
            check("d1_valid", bus_if.fs_to_ds_valid, 1);
            check("d1_pc", bus_if.fs_to_ds_bus[31:0], 32'h1c000000 + 32'(4 * (k - 2)));
            check("d1_inst", bus_if.fs_to_ds_bus[63:32], 32'h02800000 + 32'(k - 2));
         end
         tick();
      end
      settle();

      // Fill to capacity with ID stalled, then drain in order.
      for (int k = 0; k < 5; k++) begin
         drive(k < 4, ps(32'h1c000100 + 32'(4 * k), 0, 6'h0), k >= 1,
               32'h02900000 + 32'(k - 1), 0, 0);
         tick();
      end
      drive(1, ps(32'h1c000110, 0, 6'h0), 0, '0, 0, 0);
      @(negedge clk);
      check("d2_full", bus_if.fs_allowin, 0);
      tick();
      for (int j = 0; j < 4; j++) begin
         drive(j < 2, ps(32'h1c000110, 0, 6'h0), 0, '0, 0, 1);
         @(negedge clk);
         check("d2_pc", bus_if.fs_to_ds_bus[31:0], 32'h1c000100 + 32'(4 * j));
         if (j == 0) check("d2_allowin_pop", bus_if.fs_allowin, 0);
         if (j == 1) check("d2_allowin_after", bus_if.fs_allowin, 1);
         tick();
      end
      settle();

      // Flush with three WAIT entries: three responses dropped, fourth fills.
      for (int k = 0; k < 3; k++) begin
         drive(1, ps(32'h1c000200 + 32'(4 * k), 0, 6'h0), 0, '0, 0, 1);
         tick();
      end
      drive(0, '0, 0, '0, 1, 1);
      tick();
      drive(1, ps(32'h1c000800, 0, 6'h0), 0, '0, 0, 1);
      @(negedge clk);
      check("d3_busy", bus_if.fs_busy, 1);
      tick();
      for (int j = 0; j < 4; j++) begin
         drive(0, '0, 1, (j == 3) ? 32'h12345678 : 32'hdead0000, 0, 1);
         @(negedge clk);
         check("d3_hold", bus_if.fs_to_ds_valid, 0);
         tick();
      end
      idle(1);
      @(negedge clk);
      check("d3_valid", bus_if.fs_to_ds_valid, 1);
      check("d3_pc", bus_if.fs_to_ds_bus[31:0], 32'h1c000800);
      check("d3_inst", bus_if.fs_to_ds_bus[63:32], 32'h12345678);
      tick();
      settle();

      // Flush coinciding with a response and a push.
      for (int k = 0; k < 2; k++) begin
         drive(1, ps(32'h1c000300 + 32'(4 * k), 0, 6'h0), 0, '0, 0, 1);
         tick();
      end
      drive(1, ps(32'h1c000308, 0, 6'h0), 1, 32'h0badf00d, 1, 1);
      tick();
      idle(1);
      @(negedge clk);
      check("d4_busy", bus_if.fs_busy, 1);
      check("d4_empty", bus_if.fs_allowin, 1);
      tick();
      drive(0, '0, 1, 32'h0badf00d, 0, 1);
      tick();
      idle(1);
      @(negedge clk);
      check("d4_idle", bus_if.fs_busy, 0);
      tick();

      // Exception entry behind a CACOP fill.
      drive(1, ps(32'h1c000400, 0, 6'h0), 0, '0, 0, 0);
      tick();
      drive(1, ps(32'h1c000404, 1, 6'h08), 0, '0, 0, 0);
      tick();
      drive(0, '0, 1, 32'h06000000, 0, 0);
      tick();
      idle(0);
      @(negedge clk);
      check("d5_icacop", bus_if.fs_is_icacop, 1);
      check("d5_bus_icacop", bus_if.fs_to_ds_bus[73], 1);
      check("d5_pc0", bus_if.fs_to_ds_bus[31:0], 32'h1c000400);
      tick();
      idle(1);
      tick();
      @(negedge clk);
      check("d5_icacop_gone", bus_if.fs_is_icacop, 0);
      check("d5_ex_valid", bus_if.fs_to_ds_valid, 1);
      check("d5_ex_pc", bus_if.fs_to_ds_bus[31:0], 32'h1c000404);
      check("d5_ex_bit", bus_if.fs_to_ds_bus[64], 1);
      check("d5_ecode", bus_if.fs_to_ds_bus[70:65], 6'h08);
      check("d5_ex_inst", bus_if.fs_to_ds_bus[63:32], 32'h0);
      tick();
      drive(1, ps(32'h1c000410, 0, 6'h0), 0, '0, 0, 0);
      tick();
      drive(0, '0, 1, 32'h06000000, 0, 0);
      tick();
      drive(0, '0, 0, '0, 1, 0);
      tick();
      idle(1);
      @(negedge clk);
      check("d5_flush_icacop", bus_if.fs_is_icacop, 0);
      tick();
      settle();

      // Asynchronous reset with two stale responses pending.
      for (int k = 0; k < 2; k++) begin
         drive(1, ps(32'h1c000500 + 32'(4 * k), 0, 6'h0), 0, '0, 0, 1);
         tick();
      end
      drive(0, '0, 0, '0, 1, 1);
      tick();
      idle(1);
      @(negedge clk);
      check("d6_busy", bus_if.fs_busy, 1);
      tick();
      resetn = 1'b0;
      @(negedge clk);
      check("d6_allowin", bus_if.fs_allowin, 1);
      check("d6_valid", bus_if.fs_to_ds_valid, 0);
      check("d6_bus", bus_if.fs_to_ds_bus, '0);
      check("d6_icacop", bus_if.fs_is_icacop, 0);
      check("d6_busy_rst", bus_if.fs_busy, 0);
      tick();
      resetn = 1'b1;
      tick();

      // Random traffic; responses only while something is outstanding.
      for (int n = 0; n < 3000; n++) begin
         bit          pv;
         bit          ex;
         bit          dok;
         logic [31:0] rd;
         logic [40:0] pb;
         int          outst;
         outst = m_discard + m_waits();
         ex  = ($urandom % 10) == 0;
         pv  = (($urandom % 10) < 6) && (outst < 4);
         pb  = {7'($urandom), ex, $urandom & 32'hfffffffc};
         dok = (outst > 0) && ($urandom % 2 == 1);
         rd  = (($urandom % 5) == 0) ? (32'h06000000 | ($urandom & 32'h003ffff8)) : $urandom;
         drive(pv, pb, dok, rd, ($urandom % 20) == 0, ($urandom % 10) < 7);
         if (n % 700 == 699) resetn = 1'b0;
         tick();
         resetn = 1'b1;
      end
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
